// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: execute redirect, instruction memory port and decode handshake.
// The master side is the fetch stage. The slave side is the surrounding core or memory.
interface fetch_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_misalign;

    modport master (
        input  redirect_valid, redirect_pc, imem_rdata, id_ready,
        output imem_addr, id_valid, id_inst, id_pc, id_misalign
    );
    modport slave (
        output redirect_valid, redirect_pc, imem_rdata, id_ready,
        input  imem_addr, id_valid, id_inst, id_pc, id_misalign
    );
endinterface

// File: rtl/fetch_stage.sv
// RV32 fetch stage: owns the PC, reads the combinational imem and queues {pc, inst} for decode.
// Optional macro FETCH_MISALIGN_TRAP_EN turns a misaligned redirect into one fault entry plus a halt.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    fetch_if.master bus
);
    localparam int PTR_W = $clog2(FQ_DEPTH);
    localparam int CNT_W = $clog2(FQ_DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        misalign;
    } fq_entry_t;

    fq_entry_t [FQ_DEPTH-1:0] fq;
    fq_entry_t                new_entry;
    logic [31:0]              pc, target;
    logic [PTR_W-1:0]         rd_ptr, wr_ptr;
    logic [CNT_W-1:0]         count;
    logic                     pop, push, room, push_trap;

    assign bus.imem_addr   = pc;
    assign bus.id_valid    = (count != '0);
    assign bus.id_pc       = fq[rd_ptr].pc;
    assign bus.id_inst     = fq[rd_ptr].inst;
    assign bus.id_misalign = fq[rd_ptr].misalign;

    assign pop  = bus.id_valid & bus.id_ready;
    // A full queue can still accept when the head leaves this same cycle.
    assign room = (count < CNT_W'(FQ_DEPTH)) | pop;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic halt, trap_done;

    assign target    = bus.redirect_pc;
    assign push_trap = ~bus.redirect_valid & halt & ~trap_done & room;
    assign push      = (~bus.redirect_valid & ~halt & room) | push_trap;

    // halt latches on a misaligned target; the single fault entry is then emitted once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt      <= 1'b0;
            trap_done <= 1'b0;
        end else if (bus.redirect_valid) begin
            halt      <= |bus.redirect_pc[1:0];
            trap_done <= 1'b0;
        end else if (push_trap) begin
            trap_done <= 1'b1;
        end
    end
`else
    logic unused_low_bits;

    assign unused_low_bits = ^bus.redirect_pc[1:0];
    assign target          = {bus.redirect_pc[31:2], 2'b00};
    assign push_trap       = 1'b0;
    assign push            = ~bus.redirect_valid & room;
`endif

    always_comb begin
        new_entry.pc       = pc;
        new_entry.inst     = push_trap ? NOP : bus.imem_rdata;
        new_entry.misalign = push_trap;
    end

    // A redirect overrides push and pop. Decode may still consume the old head in that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            fq     <= '0;
        end else if (bus.redirect_valid) begin
            pc     <= target;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fq[wr_ptr] <= new_entry;
                wr_ptr     <= wr_ptr + PTR_W'(1);
                if (!push_trap)
                    pc <= pc + 32'd4;
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming, stall/fill, redirect, wrap and misaligned targets.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fetch_if bus ();

    fetch_stage #(.RESET_PC(32'h0), .FQ_DEPTH(2)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0008: return 32'h0020_81B3;
            32'h0000_003C: return 32'h0020_8463;
            default:       return a ^ 32'h1234_0000;
        endcase
    endfunction

    always_comb bus.imem_rdata = mem_word(bus.imem_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.id_ready       = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        // Test 1: asynchronous reset in the middle of a fetch stream.
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_valid", {31'b0, bus.id_valid}, 32'h0);
        chk("rst_pc", bus.id_pc, 32'h0);
        chk("rst_inst", bus.id_inst, 32'h0);
        chk("rst_mis", {31'b0, bus.id_misalign}, 32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rel_addr", bus.imem_addr, 32'h0);
        chk("rel_valid", {31'b0, bus.id_valid}, 32'h0);
        tick();
        chk("t1_valid", {31'b0, bus.id_valid}, 32'h1);
        chk("t1_pc", bus.id_pc, 32'h0);
        chk("t1_inst", bus.id_inst, 32'h0050_0093);
        // Test 2: continuous ready streams one instruction per cycle.
        tick();
        chk("t2_pc4", bus.id_pc, 32'h4);
        chk("t2_inst4", bus.id_inst, 32'h1234_0004);
        tick();
        chk("t2_pc8", bus.id_pc, 32'h8);
        chk("t2_inst8", bus.id_inst, 32'h0020_81B3);
        tick();
        chk("t2_pc12", bus.id_pc, 32'hC);

        // Test 3: decode stalls, the queue fills, then drains in order.
        rst_n = 1'b0;
        bus.id_ready = 1'b0;
        #1;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("t3_hold_pc", bus.imem_addr, 32'h8);
        chk("t3_head", bus.id_pc, 32'h0);
        chk("t3_valid", {31'b0, bus.id_valid}, 32'h1);
        bus.id_ready = 1'b1;
        tick();
        chk("t3_pc4", bus.id_pc, 32'h4);
        tick();
        chk("t3_pc8", bus.id_pc, 32'h8);
        tick();
        chk("t3_pc12", bus.id_pc, 32'hC);

        // Test 4: a redirect from a full queue flushes it.
        bus.id_ready = 1'b0;
        tick();
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h3C;
        tick();
        bus.redirect_valid = 1'b0;
        chk("t4_valid0", {31'b0, bus.id_valid}, 32'h0);
        chk("t4_addr", bus.imem_addr, 32'h3C);
        tick();
        chk("t4_valid1", {31'b0, bus.id_valid}, 32'h1);
        chk("t4_pc", bus.id_pc, 32'h3C);
        chk("t4_inst", bus.id_inst, 32'h0020_8463);

        // Test 5: redirect wins over a same-cycle pop, then the PC wraps past 0xFFFFFFFC.
        bus.id_ready       = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        bus.id_ready       = 1'b0;
        chk("t5_valid0", {31'b0, bus.id_valid}, 32'h0);
        chk("t5_addr", bus.imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("t5_head", bus.id_pc, 32'hFFFF_FFFC);
        chk("t5_wrap", bus.imem_addr, 32'h0);
        tick();
        chk("t5_addr4", bus.imem_addr, 32'h4);
        chk("t5_hold", bus.id_pc, 32'hFFFF_FFFC);
        bus.id_ready = 1'b1;
        tick();
        chk("t5_pc0", bus.id_pc, 32'h0);
        chk("t5_inst0", bus.id_inst, 32'h0050_0093);

`ifdef FETCH_MISALIGN_TRAP_EN
        // Test 6: a misaligned target yields one fault entry and halts until the next redirect.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h42;
        tick();
        bus.redirect_valid = 1'b0;
        chk("t6_addr", bus.imem_addr, 32'h42);
        chk("t6_valid0", {31'b0, bus.id_valid}, 32'h0);
        tick();
        chk("t6_valid1", {31'b0, bus.id_valid}, 32'h1);
        chk("t6_mis", {31'b0, bus.id_misalign}, 32'h1);
        chk("t6_nop", bus.id_inst, 32'h0000_0013);
        chk("t6_pc", bus.id_pc, 32'h42);
        chk("t6_held", bus.imem_addr, 32'h42);
        tick();
        chk("t6_once", {31'b0, bus.id_valid}, 32'h0);
        chk("t6_held2", bus.imem_addr, 32'h42);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h50;
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        chk("t6_resume_pc", bus.id_pc, 32'h50);
        chk("t6_resume_mis", {31'b0, bus.id_misalign}, 32'h0);
        tick();
        chk("t6_next", bus.id_pc, 32'h54);
`else
        // Without the trap, a misaligned target is forced onto a word boundary.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h42;
        tick();
        bus.redirect_valid = 1'b0;
        chk("al_addr", bus.imem_addr, 32'h40);
        tick();
        chk("al_pc", bus.id_pc, 32'h40);
        chk("al_mis", {31'b0, bus.id_misalign}, 32'h0);
        tick();
        chk("al_next", bus.id_pc, 32'h44);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
